// File: rtl/booth_pkg.sv
// Shared encodings for the sequential radix-2 Booth multiplier: FSM states,
// operand mode and the Booth recoding pairs that select add or subtract.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One Booth iteration: add/subtract the multiplicand per {q[0],q_1}, then
// arithmetic-shift {acc,q,q_1} right by one. Purely combinational.
module booth_step
  import booth_pkg::*;
#(
  parameter int W = 9
) (
  input  logic [W-1:0] i_acc,
  input  logic [W-1:0] i_q,
  input  logic         i_q_1,
  input  logic [W-1:0] i_mcand,
  output logic [W-1:0] o_acc,
  output logic [W-1:0] o_q,
  output logic         o_q_1
);

  logic [W-1:0] w_sum;

  always_comb begin
    w_sum = i_acc;
    case ({i_q[0], i_q_1})
      PAIR_ADD: w_sum = i_acc + i_mcand;
      PAIR_SUB: w_sum = i_acc - i_mcand;
      default:  w_sum = i_acc;
    endcase
  end

  // The shift replicates the MSB of the updated accumulator, not the old one.
  assign o_acc = {w_sum[W-1], w_sum[W-1:1]};
  assign o_q   = {w_sum[0], i_q[W-1:1]};
  assign o_q_1 = i_q[0];

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per operation; result valid
// N+1 cycles after acceptance, held in DONE until out_ready_i; abort_i cancels CALC/DONE.
module booth_multiplier_seq
  import booth_pkg::*;
#(
  parameter int DATA_SIZE = 8
) (
  input  logic                     clk_i,
  input  logic                     reset_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     signed_i,
  input  logic [DATA_SIZE-1:0]     multiplicand_i,
  input  logic [DATA_SIZE-1:0]     multiplier_i,
  input  logic                     abort_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [2*DATA_SIZE-1:0]   product_o,
  output logic                     busy_o
);

  localparam int N  = DATA_SIZE;
  localparam int W  = N + 1;
  localparam int CW = $clog2(W + 1);

  state_t             r_state;
  logic [W-1:0]       r_acc;
  logic [W-1:0]       r_q;
  logic               r_q_1;
  logic [W-1:0]       r_mcand;
  logic [CW-1:0]      r_count;
  logic [2*N-1:0]     r_product;
  logic               r_in_ready;
  logic               r_out_valid;
  logic               r_busy;

  logic [W-1:0]       w_ext_m;
  logic [W-1:0]       w_ext_q;
  logic [W-1:0]       w_acc_nxt;
  logic [W-1:0]       w_q_nxt;
  logic               w_q_1_nxt;
  logic [2*N-1:0]     w_prod_low;

  // One extra bit lets a single signed datapath serve both operand modes.
  assign w_ext_m = (signed_i == MODE_SIGNED) ? {multiplicand_i[N-1], multiplicand_i}
                                             : {1'b0, multiplicand_i};
  assign w_ext_q = (signed_i == MODE_SIGNED) ? {multiplier_i[N-1], multiplier_i}
                                             : {1'b0, multiplier_i};

  booth_step #(
    .W(W)
  ) u_step (
    .i_acc   (r_acc),
    .i_q     (r_q),
    .i_q_1   (r_q_1),
    .i_mcand (r_mcand),
    .o_acc   (w_acc_nxt),
    .o_q     (w_q_nxt),
    .o_q_1   (w_q_1_nxt)
  );

  assign w_prod_low = {w_acc_nxt[W-3:0], w_q_nxt};

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_q         <= '0;
      r_q_1       <= 1'b0;
      r_mcand     <= '0;
      r_count     <= '0;
      r_product   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            r_state    <= CALC;
            r_acc      <= '0;
            r_q        <= w_ext_q;
            r_q_1      <= 1'b0;
            r_mcand    <= w_ext_m;
            r_count    <= CW'(W);
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        CALC: begin
          if (abort_i) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
          end else begin
            r_acc   <= w_acc_nxt;
            r_q     <= w_q_nxt;
            r_q_1   <= w_q_1_nxt;
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              r_state     <= DONE;
              r_product   <= w_prod_low;
              r_out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (abort_i || out_ready_i) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = r_in_ready;
  assign out_valid_o = r_out_valid;
  assign busy_o      = r_busy;
  assign product_o   = r_product;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Scoreboard bench for booth_multiplier_seq at N=8 and N=16; sel picks which
// instance the shared stimulus drives and which outputs are observed.
module tb_booth_multiplier_seq;

  logic        clk;
  logic        reset_n;
  logic        sel;
  logic        in_valid;
  logic        sgn;
  logic        abort;
  logic        out_ready;
  logic [15:0] m;
  logic [15:0] q;

  logic        rdy8, vld8, busy8;
  logic [15:0] p8;
  logic        rdy16, vld16, busy16;
  logic [31:0] p16;

  logic        rdy, vld, busy;
  logic [31:0] prod;

  logic [31:0] sb[$];
  int          n_vec;
  int          n_err;

  booth_multiplier_seq #(.DATA_SIZE(8)) u_dut8 (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .in_valid_i     (in_valid & ~sel),
    .in_ready_o     (rdy8),
    .signed_i       (sgn),
    .multiplicand_i (m[7:0]),
    .multiplier_i   (q[7:0]),
    .abort_i        (abort & ~sel),
    .out_valid_o    (vld8),
    .out_ready_i    (out_ready & ~sel),
    .product_o      (p8),
    .busy_o         (busy8)
  );

  booth_multiplier_seq #(.DATA_SIZE(16)) u_dut16 (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .in_valid_i     (in_valid & sel),
    .in_ready_o     (rdy16),
    .signed_i       (sgn),
    .multiplicand_i (m),
    .multiplier_i   (q),
    .abort_i        (abort & sel),
    .out_valid_o    (vld16),
    .out_ready_i    (out_ready & sel),
    .product_o      (p16),
    .busy_o         (busy16)
  );

  assign rdy  = sel ? rdy16  : rdy8;
  assign vld  = sel ? vld16  : vld8;
  assign busy = sel ? busy16 : busy8;
  assign prod = sel ? p16    : {16'h0, p8};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic s, input logic [15:0] a,
                                        input logic [15:0] b, input int n);
    logic [31:0] ea, eb, r;
    if (n == 8) begin
      ea = s ? {{24{a[7]}}, a[7:0]} : {24'h0, a[7:0]};
      eb = s ? {{24{b[7]}}, b[7:0]} : {24'h0, b[7:0]};
    end else begin
      ea = s ? {{16{a[15]}}, a} : {16'h0, a};
      eb = s ? {{16{b[15]}}, b} : {16'h0, b};
    end
    r = ea * eb;
    return (n == 8) ? {16'h0, r[15:0]} : r;
  endfunction

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic start_op(input logic s, input logic [15:0] mm, input logic [15:0] qq,
                          input logic push, input logic [31:0] exp);
    int k;
    k = 0;
    while (!rdy && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("in_ready_wait", {31'h0, rdy}, 32'h1);
    sgn      = s;
    m        = mm;
    q        = qq;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (push) sb.push_back(exp);
    check_eq("accept_busy_rdy", {30'h0, busy, rdy}, 32'h2);
  endtask

  task automatic wait_out(input string tag, input int lat);
    int k;
    logic [31:0] e;
    k = 0;
    while (!vld && k < lat + 20) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_latency"}, 32'(k), 32'(lat));
    e = (sb.size() > 0) ? sb.pop_front() : 32'hxxxxxxxx;
    check_eq(tag, prod, e);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_handshake", {29'h0, vld, rdy, busy}, 32'h2);
  endtask

  task automatic run(input string tag, input logic s, input logic [15:0] mm,
                     input logic [15:0] qq, input logic [31:0] exp, input int lat);
    start_op(s, mm, qq, 1'b1, exp);
    wait_out(tag, lat);
    handshake();
  endtask

  task automatic reset_mid_calc(input string tag, input int cycles);
    start_op(1'b0, 16'h00AB, 16'h00CD, 1'b0, 32'h0);
    repeat (cycles) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_eq({tag, "_ctl"}, {29'h0, rdy, vld, busy}, 32'h4);
    check_eq({tag, "_prod"}, prod, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic        s;
    logic [15:0] mm, qq;
    logic [31:0] e;
    int          hits;

    n_vec     = 0;
    n_err     = 0;
    reset_n   = 1'b0;
    sel       = 1'b0;
    in_valid  = 1'b0;
    sgn       = 1'b0;
    abort     = 1'b0;
    out_ready = 1'b0;
    m         = '0;
    q         = '0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_eq("reset8_ctl", {29'h0, rdy, vld, busy}, 32'h4);
    check_eq("reset8_prod", prod, 32'h0);
    sel = 1'b1;
    #1;
    check_eq("reset16_ctl", {29'h0, rdy, vld, busy}, 32'h4);
    check_eq("reset16_prod", prod, 32'h0);
    sel = 1'b0;
    @(negedge clk);

    run("s_m3x5",   1'b1, 16'h00FD, 16'h0005, 32'h0000FFF1, 9);
    run("u_ffxff",  1'b0, 16'h00FF, 16'h00FF, 32'h0000FE01, 9);
    run("s_ffxff",  1'b1, 16'h00FF, 16'h00FF, 32'h00000001, 9);
    run("s_80x80",  1'b1, 16'h0080, 16'h0080, 32'h00004000, 9);
    run("s_80x7f",  1'b1, 16'h0080, 16'h007F, 32'h0000C080, 9);
    for (int i = 0; i < 10; i++) begin
      s  = 1'($urandom_range(0, 1));
      mm = {8'h0, 8'($urandom)};
      qq = {8'h0, 8'($urandom)};
      run("rand8", s, mm, qq, model(s, mm, qq, 8), 9);
    end

    // Output held off while new operands wait on the input.
    e = model(1'b1, 16'h0012, 16'h00C4, 8);
    start_op(1'b1, 16'h0012, 16'h00C4, 1'b1, e);
    wait_out("hold_first", 9);
    sgn      = 1'b0;
    m        = 16'h0007;
    q        = 16'h0006;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check_eq("hold_prod", prod, e);
      check_eq("hold_rdy_vld", {30'h0, rdy, vld}, 32'h1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("hold_release", {29'h0, vld, rdy, busy}, 32'h2);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    sb.push_back(32'h0000002A);
    check_eq("hold_next_accept", {30'h0, busy, rdy}, 32'h2);
    wait_out("hold_next", 9);
    handshake();

    // Abort in the 4th CALC cycle.
    start_op(1'b1, 16'h0055, 16'h0033, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_ctl", {29'h0, vld, rdy, busy}, 32'h2);
    hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (vld) hits++;
    end
    check_eq("abort_no_valid", 32'(hits), 32'h0);
    run("after_abort", 1'b0, 16'h0007, 16'h0006, 32'h0000002A, 9);

    reset_mid_calc("arst8", 3);

    sel = 1'b1;
    #1;
    run("w16_8000x2", 1'b1, 16'h8000, 16'h0002, 32'hFFFF0000, 17);
    run("w16_u_full", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 17);
    for (int i = 0; i < 4; i++) begin
      s  = 1'($urandom_range(0, 1));
      mm = 16'($urandom);
      qq = 16'($urandom);
      run("rand16", s, mm, qq, model(s, mm, qq, 16), 17);
    end
    reset_mid_calc("arst16", 5);
    run("w16_after_rst", 1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 17);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
